// File: rtl/output_drain_controller.sv
// -----------------------------------------------------------------------------
// output_drain_controller
//
// Purpose:
//   Drains the per-filter output BRAMs after an accumulation pass and streams
//   their contents out on a valid/ready interface. Reads are filter-major and
//   address-minor: every address 0..last of filter 0, then filter 1, and so on.
//   Read data comes back one cycle after the read strobe and lands in a
//   2-entry FIFO tagged with an end-of-pass marker. The stream is driven from
//   the FIFO head.
//
// Optional feature:
//   OUTPUT_DRAIN_CLEAR_EN - when defined, adds bram_clr_we_o. It pulses with
//   every read strobe so BRAM port B can write zero to the address just read,
//   leaving the BRAM cleared for the next accumulation pass. When undefined,
//   the port does not exist and BRAM contents are left untouched.
//
// Ports:
//   clk_i            sole clock, rising edge
//   general_rst_i    synchronous active-high reset
//   start_i          starts one drain pass (accepted only when idle)
//   num_filters_i    number of filters to drain (1..NUMBER_SUPPORTED_FILTERS)
//   last_addr_i      inclusive last BRAM address of each filter
//   bram_ready_i     BRAMs may be read
//   sel_mux_final_o  filter select to the final output mux
//   bram_addr_o      BRAM read address
//   bram_rd_en_o     BRAM read strobe
//   bram_data_i      BRAM read data, valid one cycle after bram_rd_en_o
//   out_data_o       stream data
//   out_valid_o      stream valid
//   out_ready_i      stream ready
//   out_last_o       final word of the pass
//   busy_o           pass in progress
//   done_o           one-cycle completion pulse
//   bram_clr_we_o    (OUTPUT_DRAIN_CLEAR_EN only) BRAM clear write strobe
// -----------------------------------------------------------------------------
module output_drain_controller #(
    parameter int NUMBER_SUPPORTED_FILTERS = 30,
    parameter int BRAM_ADDR_WIDTH          = 11,
    parameter int DATA_WIDTH               = 16
) (
    input  logic                                          clk_i,
    input  logic                                          general_rst_i,
    input  logic                                          start_i,
    input  logic [$clog2(NUMBER_SUPPORTED_FILTERS+1)-1:0] num_filters_i,
    input  logic [BRAM_ADDR_WIDTH-1:0]                    last_addr_i,
    input  logic                                          bram_ready_i,
    output logic [$clog2(NUMBER_SUPPORTED_FILTERS)-1:0]   sel_mux_final_o,
    output logic [BRAM_ADDR_WIDTH-1:0]                    bram_addr_o,
    output logic                                          bram_rd_en_o,
    input  logic [DATA_WIDTH-1:0]                         bram_data_i,
    output logic [DATA_WIDTH-1:0]                         out_data_o,
    output logic                                          out_valid_o,
    input  logic                                          out_ready_i,
    output logic                                          out_last_o,
    output logic                                          busy_o,
    output logic                                          done_o
`ifdef OUTPUT_DRAIN_CLEAR_EN
    ,
    output logic                                          bram_clr_we_o
`endif
);

    localparam int NF_W  = $clog2(NUMBER_SUPPORTED_FILTERS + 1);
    localparam int SEL_W = $clog2(NUMBER_SUPPORTED_FILTERS);

    localparam logic [NF_W-1:0]            NF_ONE   = NF_W'(1);
    localparam logic [NF_W-1:0]            NF_MAX   = NF_W'(NUMBER_SUPPORTED_FILTERS);
    localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = BRAM_ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Control state
    state_t                     state_q,    state_d;
    logic [NF_W-1:0]            f_q,        f_d;
    logic [BRAM_ADDR_WIDTH-1:0] a_q,        a_d;
    logic [NF_W-1:0]            nf_q,       nf_d;
    logic [BRAM_ADDR_WIDTH-1:0] last_q,     last_d;

    // Read-return tracking: a read issued this cycle returns next cycle
    logic                       inflight_q, inflight_d;
    logic [NF_W-1:0]            ret_sel_q,  ret_sel_d;
    logic                       ret_last_q, ret_last_d;

    // 2-entry output FIFO
    logic [1:0]                 cnt_q,      cnt_d;
    logic                       wr_ptr_q,   wr_ptr_d;
    logic                       rd_ptr_q,   rd_ptr_d;
    logic [DATA_WIDTH-1:0]      fifo_data_q [2];
    logic                       fifo_last_q [2];

    logic [1:0] pending;
    logic       boundary_wait;
    logic       issue;
    logic       at_last_addr;
    logic       at_last_filter;
    logic       start_legal;
    logic       push;
    logic       pop;

    // Words the FIFO is already committed to hold: stored plus returning.
    assign pending = cnt_q + {1'b0, inflight_q};

    // The final mux is still pointed at the previous filter while its last
    // read returns; hold off the first read of the new filter until then.
    assign boundary_wait = inflight_q && (ret_sel_q != f_q);

    assign issue = (state_q == ST_ISSUE) && bram_ready_i &&
                   (pending < 2'd2) && !boundary_wait;

    assign at_last_addr   = (a_q == last_q);
    assign at_last_filter = (f_q == (nf_q - NF_ONE));
    assign start_legal    = (num_filters_i != '0) && (num_filters_i <= NF_MAX);

    assign push = inflight_q;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        state_d    = state_q;
        f_d        = f_q;
        a_d        = a_q;
        nf_d       = nf_q;
        last_d     = last_q;
        inflight_d = issue;
        ret_sel_d  = ret_sel_q;
        ret_last_d = ret_last_q;

        if (issue) begin
            ret_sel_d  = f_q;
            ret_last_d = at_last_filter && at_last_addr;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (start_legal) begin
                        nf_d    = num_filters_i;
                        last_d  = last_addr_i;
                        f_d     = '0;
                        a_d     = '0;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    if (at_last_filter && at_last_addr) begin
                        state_d = ST_FLUSH;
                    end else if (at_last_addr) begin
                        a_d = '0;
                        f_d = f_q + NF_ONE;
                    end else begin
                        a_d = a_q + ADDR_ONE;
                    end
                end
            end
            ST_FLUSH: begin
                if (!inflight_q && (cnt_q == 2'd0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (general_rst_i) begin
            state_q    <= ST_IDLE;
            f_q        <= '0;
            a_q        <= '0;
            nf_q       <= '0;
            last_q     <= '0;
            inflight_q <= 1'b0;
            ret_sel_q  <= '0;
            ret_last_q <= 1'b0;
            cnt_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            f_q        <= f_d;
            a_q        <= a_d;
            nf_q       <= nf_d;
            last_q     <= last_d;
            inflight_q <= inflight_d;
            ret_sel_q  <= ret_sel_d;
            ret_last_q <= ret_last_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= bram_data_i;
            fifo_last_q[wr_ptr_q] <= ret_last_q;
        end
    end

    // During a data-return cycle the mux follows the returning read's filter.
    assign sel_mux_final_o = SEL_W'(inflight_q ? ret_sel_q : f_q);
    assign bram_addr_o     = a_q;
    assign bram_rd_en_o    = issue;

    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = out_valid_o ? fifo_data_q[rd_ptr_q] : '0;
    assign out_last_o  = out_valid_o ? fifo_last_q[rd_ptr_q] : 1'b0;

    assign busy_o = (state_q == ST_ISSUE) || (state_q == ST_FLUSH);
    assign done_o = (state_q == ST_DONE);

`ifdef OUTPUT_DRAIN_CLEAR_EN
    assign bram_clr_we_o = issue;
`endif

endmodule

// File: tb/tb_output_drain_controller.sv
module tb_output_drain_controller;

    localparam int NSF  = 30;
    localparam int AW   = 11;
    localparam int DW   = 16;
    localparam int NFW  = $clog2(NSF + 1);
    localparam int SELW = $clog2(NSF);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [NFW-1:0]  num_filters;
    logic [AW-1:0]   last_addr;
    logic            bram_ready;
    logic [SELW-1:0] sel;
    logic [AW-1:0]   bram_addr;
    logic            bram_rd_en;
    logic [DW-1:0]   bram_data;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;
    logic            done;
`ifdef OUTPUT_DRAIN_CLEAR_EN
    logic            bram_clr_we;
`endif

    always #5 clk = ~clk;

    output_drain_controller #(
        .NUMBER_SUPPORTED_FILTERS(NSF),
        .BRAM_ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk_i(clk),
        .general_rst_i(rst),
        .start_i(start),
        .num_filters_i(num_filters),
        .last_addr_i(last_addr),
        .bram_ready_i(bram_ready),
        .sel_mux_final_o(sel),
        .bram_addr_o(bram_addr),
        .bram_rd_en_o(bram_rd_en),
        .bram_data_i(bram_data),
        .out_data_o(out_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_last_o(out_last),
        .busy_o(busy),
        .done_o(done)
`ifdef OUTPUT_DRAIN_CLEAR_EN
        ,
        .bram_clr_we_o(bram_clr_we)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Contents of filter f at address a: a simple formula, optionally salted.
    logic [15:0] salt = 16'h0000;

    function automatic logic [15:0] word_fn(input int f, input int a, input logic [15:0] s);
        return 16'(f * 16 + a) ^ s;
    endfunction

    // BRAM bank + final mux: address captured at the read, filter chosen by
    // the mux select during the return cycle.
    logic          ret_v = 1'b0;
    logic [AW-1:0] ret_addr = '0;
    always @(posedge clk) begin
        ret_v    <= bram_rd_en;
        ret_addr <= bram_addr;
    end
    always_comb begin
        bram_data = 16'hDEAD;
        if (ret_v) bram_data = word_fn(int'(sel), int'(ret_addr), salt);
    end

    // Passive observer, sampling mid-cycle.
    int          cyc = 0;
    logic [16:0] got_q[$];
    int          reads = 0;
    int          clr_cnt = 0;
    int          done_cnt = 0;
    int          done_stamp = 0;
    int          last_xfer_stamp = 0;
    int          hold_err = 0;
    int          rd_err = 0;
    int          occ_err = 0;
    int          outst = 0;
    logic        held_v = 1'b0;
    logic [15:0] held_d = '0;
    logic        held_l = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            outst  = 0;
            held_v = 1'b0;
        end else begin
            if (held_v && (!out_valid || out_data !== held_d || out_last !== held_l))
                hold_err++;
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
            if (bram_rd_en) begin
                reads++;
                outst++;
                if (!bram_ready) rd_err++;
            end
`ifdef OUTPUT_DRAIN_CLEAR_EN
            if (bram_clr_we) clr_cnt++;
`endif
            if (outst > 2) occ_err++;
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_data});
                last_xfer_stamp = cyc;
                outst--;
            end
            if (done) begin
                done_cnt++;
                done_stamp = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_sel"},   32'(sel),        0);
        chk({tag, "_addr"},  32'(bram_addr),  0);
        chk({tag, "_rden"},  32'(bram_rd_en), 0);
        chk({tag, "_data"},  32'(out_data),   0);
        chk({tag, "_valid"}, 32'(out_valid),  0);
        chk({tag, "_last"},  32'(out_last),   0);
        chk({tag, "_busy"},  32'(busy),       0);
        chk({tag, "_done"},  32'(done),       0);
    endtask

    // One drain pass. mode 0: all ready; 1: out_ready toggles each cycle;
    // 2: bram_ready low for 5 cycles once address 2 is presented;
    // 3: random out_ready and bram_ready.
    task automatic run_pass(input int nf, input int la, input int mode,
                            input logic [15:0] s, input string tag);
        logic [16:0] exp_q[$];
        int  base_w, base_r, base_d, base_h, base_re, base_o, base_c;
        int  start_stamp, budget, stall_left, n;
        bit  legal, timed_out, stall_done;
        salt       = s;
        legal      = (nf >= 1) && (nf <= NSF);
        stall_left = 0;
        stall_done = 1'b0;
        timed_out  = 1'b1;
        if (legal)
            for (int f = 0; f < nf; f++)
                for (int a = 0; a <= la; a++)
                    exp_q.push_back({(f == nf - 1) && (a == la), word_fn(f, a, s)});
        base_w  = got_q.size();
        base_r  = reads;
        base_d  = done_cnt;
        base_h  = hold_err;
        base_re = rd_err;
        base_o  = occ_err;
        base_c  = clr_cnt;

        start       = 1'b1;
        num_filters = NFW'(nf);
        last_addr   = AW'(la);
        out_ready   = 1'b1;
        bram_ready  = 1'b1;
        @(negedge clk);
        start_stamp = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        if (legal) chk({tag, "_busy_after_start"}, 32'(busy), 1);
        else       chk({tag, "_done_after_start"}, 32'(done), 1);

        budget = 40 * (exp_q.size() + 2) + 50;
        for (int c = 0; c < budget; c++) begin
            if (done_cnt != base_d) begin
                timed_out = 1'b0;
                break;
            end
            case (mode)
                1: out_ready = c[0];
                2: begin
                    if (!stall_done && busy && bram_addr == AW'(2)) begin
                        stall_left = 5;
                        stall_done = 1'b1;
                    end
                    bram_ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
                3: begin
                    out_ready  = 1'($urandom_range(0, 1));
                    bram_ready = ($urandom_range(0, 3) != 0);
                end
                default: ;
            endcase
            @(posedge clk); #1;
        end
        out_ready  = 1'b1;
        bram_ready = 1'b1;
        chk({tag, "_timeout"}, 32'(timed_out), 0);
        repeat (3) @(posedge clk);
        #1;

        n = got_q.size() - base_w;
        chk({tag, "_word_count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            chk($sformatf("%s_word%0d", tag, i), 32'(got_q[base_w + i]), 32'(exp_q[i]));
        chk({tag, "_read_count"}, 32'(reads - base_r), 32'(exp_q.size()));
        chk({tag, "_done_pulses"}, 32'(done_cnt - base_d), 1);
        chk({tag, "_hold_violations"}, 32'(hold_err - base_h), 0);
        chk({tag, "_read_while_not_ready"}, 32'(rd_err - base_re), 0);
        chk({tag, "_occupancy_over_2"}, 32'(occ_err - base_o), 0);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        // Legal pass: FIFO empties the cycle after the final transfer, DONE follows.
        if (legal) chk({tag, "_done_timing"}, 32'(done_stamp - last_xfer_stamp), 2);
        else       chk({tag, "_done_timing"}, 32'(done_stamp - start_stamp), 1);
        if (mode == 2) chk({tag, "_stall_window_hit"}, 32'(stall_done), 1);
`ifdef OUTPUT_DRAIN_CLEAR_EN
        chk({tag, "_clear_count"}, 32'(clr_cnt - base_c), 32'(reads - base_r));
`else
        chk({tag, "_clear_count"}, 32'(clr_cnt - base_c), 0);
`endif
    endtask

    initial begin
        int base_w;
        bit reached;
        rst         = 1'b1;
        start       = 1'b0;
        num_filters = '0;
        last_addr   = '0;
        bram_ready  = 1'b1;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_pass(2, 3, 0, 16'h0000, "basic");
        run_pass(2, 3, 1, 16'h0000, "toggle");
        run_pass(2, 3, 2, 16'h0000, "stall");
        run_pass(0, 3, 0, 16'h0000, "nf0");
        run_pass(31, 3, 0, 16'h0000, "nf31");
        run_pass(3, 0, 0, 16'h5A5A, "la0");
        run_pass(30, 0, 3, 16'(($urandom)), "nf30");
        for (int k = 0; k < 4; k++)
            run_pass(int'($urandom_range(1, 6)), int'($urandom_range(0, 9)), 3,
                     16'($urandom), $sformatf("rand%0d", k));

        // Reset in the middle of a pass, once word 5 of 8 is up next.
        salt        = 16'h0000;
        base_w      = got_q.size();
        start       = 1'b1;
        num_filters = NFW'(2);
        last_addr   = AW'(3);
        @(posedge clk); #1;
        start   = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (got_q.size() - base_w >= 4) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("midreset_reached_word5", 32'(reached), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_outputs_zero("midreset");
        rst = 1'b0;
        @(posedge clk); #1;
        run_pass(2, 3, 0, 16'h0000, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_drain_controller.md
OUTPUT_DRAIN_CONTROLLER -- requirements
Module: output_drain_controller

Interface
REQ-001 SHALL have parameter NUMBER_SUPPORTED_FILTERS, default 30, the count of per-filter output BRAMs.
REQ-002 SHALL have parameter BRAM_ADDR_WIDTH, default 11, the output BRAM address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, the output word width (F_WIDTH + I_WIDTH).
REQ-004 SHALL have one clock and a synchronous active-high reset, listed first:
- clk_i  in  1  sole clock; all state updates on the rising edge.
- general_rst_i  in  1  synchronous, active-high reset.
REQ-005 SHALL have the remaining ports:
- start_i  in  1  pulse that starts one drain pass.
- num_filters_i  in  $clog2(NUMBER_SUPPORTED_FILTERS+1)  filters to drain; legal 1..NUMBER_SUPPORTED_FILTERS.
- last_addr_i  in  BRAM_ADDR_WIDTH  inclusive last BRAM address per filter.
- bram_ready_i  in  1  output BRAMs free for reading.
- sel_mux_final_o  out  $clog2(NUMBER_SUPPORTED_FILTERS)  filter select to the final output mux.
- bram_addr_o  out  BRAM_ADDR_WIDTH  read address.
- bram_rd_en_o  out  1  read issue strobe.
- bram_data_i  in  DATA_WIDTH  read data, valid exactly 1 cycle after bram_rd_en_o.
- out_data_o  out  DATA_WIDTH  stream data.
- out_valid_o  out  1  stream valid.
- out_ready_i  in  1  stream ready.
- out_last_o  out  1  marks the final word of the pass.
- busy_o  out  1  high while the pass runs.
- done_o  out  1  one-cycle completion pulse.

Function
REQ-006 SHALL implement states IDLE, ISSUE, FLUSH, DONE.
REQ-007 In IDLE, start_i SHALL latch num_filters_i and last_addr_i, clear filter index f and address a, and move to ISSUE; start_i SHALL be ignored in every other state.
REQ-008 Read order SHALL be filter-major, address-minor: (f=0,a=0..last), then (f=1,...), and so on.
REQ-009 In ISSUE, bram_rd_en_o SHALL assert only when bram_ready_i=1 and (FIFO occupancy + in-flight reads) < 2; bram_addr_o SHALL equal a and sel_mux_final_o SHALL equal f.
REQ-010 sel_mux_final_o SHALL stay stable through the data-return cycle; when f advances, no read SHALL issue until the in-flight read has returned (one bubble per filter boundary).
REQ-011 Returned bram_data_i SHALL be written into a 2-entry FIFO with a last tag; out_data_o, out_valid_o and out_last_o SHALL be driven from the FIFO head.
REQ-012 A word SHALL transfer when out_valid_o=1 and out_ready_i=1; out_data_o and out_last_o SHALL hold while out_valid_o=1 and out_ready_i=0.
REQ-013 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged; the FIFO SHALL never overflow.
REQ-014 After issuing (f=num_filters-1, a=last_addr), the block SHALL enter FLUSH and stay there until in-flight=0 and the FIFO is empty.
REQ-015 DONE SHALL last one cycle, assert done_o, and return to IDLE.
REQ-016 busy_o SHALL be high in ISSUE and FLUSH.
REQ-017 Address a SHALL wrap from last_addr to 0 as f increments; last_addr_i=0 SHALL yield one word per filter.
REQ-018 bram_ready_i=0 SHALL stall issue only; the FIFO SHALL continue to drain.
REQ-019 num_filters_i=0 or num_filters_i>NUMBER_SUPPORTED_FILTERS SHALL go IDLE to DONE directly with no reads or stream words.

Reset
REQ-020 general_rst_i SHALL take effect on the next clock edge and put the block in IDLE, including mid-pass.
REQ-021 Reset SHALL empty the FIFO, clear in-flight, f and a, and drive every output to 0; data returned after reset SHALL be discarded.

Configuration
REQ-022 With macro OUTPUT_DRAIN_CLEAR_EN defined, the block SHALL add output bram_clr_we_o (1 bit).
- bram_clr_we_o SHALL pulse with each bram_rd_en_o, so port B writes 0 to bram_addr_o one cycle later and the BRAM is zeroed for the next accumulation pass.
REQ-023 Without OUTPUT_DRAIN_CLEAR_EN, the port SHALL be absent and BRAM contents SHALL be left unchanged.

Verification
REQ-024 num_filters=2, last_addr=3, out_ready=1, data=f*16+a -> 8 words 0,1,2,3,16,17,18,19; out_last only on 19; done_o 1 cycle after FIFO empties.
REQ-025 Same config, out_ready toggling 1/0 every cycle -> identical sequence, no drops or duplicates, in-flight+FIFO never above 2.
REQ-026 bram_ready_i=0 for 5 cycles at a=2 -> no bram_rd_en_o during that window; stream resumes in order.
REQ-027 general_rst_i asserted at word 5 of 8 -> IDLE and all outputs 0 next cycle; a new start_i yields a full clean pass.
REQ-028 num_filters=0 -> done_o 1 cycle after start, zero reads; with OUTPUT_DRAIN_CLEAR_EN, a normal pass shows bram_clr_we_o count equal to the read count (8).
